// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment interface.
// Glyph patterns are gfedcba, active-high (segment lit = 1).
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Index n holds the glyph for hex digit n.
  localparam logic [15:0][6:0] GLYPH_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [3:0] AN_IDLE     = 4'hF;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       bad;
  } glyph_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: active-high gfedcba pattern to nibble plus blank/bad flags.
// Unknown and blank patterns both decode to nibble 0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output glyph_t     glyph
);

  logic [15:0] hit;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_match
      assign hit[gi] = (pattern == GLYPH_HEX[gi]);
    end
  endgenerate

  always_comb begin
    glyph = '0;
    for (int k = 0; k < 16; k++) begin
      if (hit[k]) begin
        glyph.nibble = 4'(k);
      end
    end
    glyph.blank = (pattern == GLYPH_BLANK);
    glyph.bad   = !glyph.blank && (hit == '0);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a scanned 4-digit 7-segment bus, captures each settled digit slot
// and publishes complete 16-bit frames with per-digit dp/blank and error flags.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [6:0]  seg,
  input  logic        seg_P,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        an_err,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [3:0]      s_an_reg;
  logic [6:0]      s_seg_reg;
  logic            s_seg_p_reg;
  logic [SW-1:0]   stable_cnt_reg;
  logic [TW-1:0]   timeout_cnt_reg;
  logic [3:0]      mask_reg;
  logic [3:0]      dp_s_reg;
  logic [3:0]      blank_s_reg;
  logic [3:0]      bad_s_reg;
  logic [3:0][3:0] nib_s_reg;

  logic   pins_same;
  logic   capture;
  logic   an_onehot;
  logic   capture_digit;
  logic   capture_bad_an;
  logic   timeout_hit;
  logic   commit;
  logic [6:0] pattern;
  glyph_t glyph;

  // The pins match s_in exactly when the next s_in equals the current one.
  assign pins_same      = ({AN, seg, seg_P} == {s_an_reg, s_seg_reg, s_seg_p_reg});
  assign capture        = pins_same && (stable_cnt_reg == SW'(SETTLE - 2));
  assign an_onehot      = $onehot(~s_an_reg);
  assign capture_digit  = capture && an_onehot;
  assign capture_bad_an = capture && !an_onehot && (s_an_reg != AN_IDLE);
  assign timeout_hit    = !capture_digit && (timeout_cnt_reg == TW'(TIMEOUT - 1));
  assign commit         = (mask_reg == 4'hF);
  assign pattern        = ~s_seg_reg;

  seg7_glyph_decode u_decode (
    .pattern (pattern),
    .glyph   (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an_reg       <= '0;
      s_seg_reg      <= '0;
      s_seg_p_reg    <= 1'b0;
      stable_cnt_reg <= '0;
    end else begin
      s_an_reg    <= AN;
      s_seg_reg   <= seg;
      s_seg_p_reg <= seg_P;
      if (!pins_same) begin
        stable_cnt_reg <= '0;
      end else if (stable_cnt_reg != SW'(SETTLE)) begin
        stable_cnt_reg <= stable_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt_reg <= '0;
    end else if (capture_digit) begin
      timeout_cnt_reg <= '0;
    end else if (timeout_cnt_reg != TW'(TIMEOUT)) begin
      timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
    end
  end

  // A capture and a commit never share a cycle: the commit follows the
  // capture that completed the mask, and the next capture is SETTLE away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg    <= '0;
      dp_s_reg    <= '0;
      blank_s_reg <= '0;
      bad_s_reg   <= '0;
      nib_s_reg   <= '0;
    end else begin
      if (commit || timeout_hit) begin
        mask_reg <= '0;
      end else if (capture_digit) begin
        mask_reg <= mask_reg | ~s_an_reg;
      end

      if (commit) begin
        blank_s_reg <= '0;
        bad_s_reg   <= '0;
      end else if (capture_digit) begin
        for (int i = 0; i < 4; i++) begin
          if (!s_an_reg[i]) begin
            nib_s_reg[i]   <= glyph.nibble;
            blank_s_reg[i] <= glyph.blank;
            bad_s_reg[i]   <= glyph.bad;
            dp_s_reg[i]    <= ~s_seg_p_reg;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      dp          <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      an_err      <= 1'b0;
      stale       <= 1'b1;
    end else begin
      frame_valid <= commit;
      an_err      <= capture_bad_an;
      if (commit) begin
        value     <= nib_s_reg;
        dp        <= dp_s_reg;
        blank     <= blank_s_reg;
        frame_err <= |bad_s_reg;
        stale     <= 1'b0;
      end else if (timeout_hit) begin
        stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised bench for seg7_scan_decoder against a digit-level frame model.
// Frames are compared through an observed/expected queue pair, including pulse timing.
module tb_seg7_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  AN    = 4'hF;
  logic [6:0]  seg   = 7'h7F;
  logic        seg_P = 1'b1;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        frame_err;
  logic        an_err;
  logic        stale;

  seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .AN          (AN),
    .seg         (seg),
    .seg_P       (seg_P),
    .value       (value),
    .dp          (dp),
    .blank       (blank),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .an_err      (an_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        err;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  frame_t mon_f;
  int an_err_seen = 0;
  int an_err_exp  = 0;

  always @(negedge clk) begin
    if (frame_valid) begin
      mon_f.cyc   = cyc;
      mon_f.value = value;
      mon_f.dp    = dp;
      mon_f.blank = blank;
      mon_f.err   = frame_err;
      obs_q.push_back(mon_f);
    end
    if (an_err) an_err_seen++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: digit slots filled by settled captures, frame emitted when all four are in.
  logic [6:0] gl [16];
  logic [3:0] m_mask;
  logic [3:0] m_nib [4];
  logic [3:0] m_dp, m_blank, m_bad;
  logic       m_stale;
  frame_t     m_last;

  function automatic bit is_glyph(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (gl[k] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mask = 0; m_dp = 0; m_blank = 0; m_bad = 0; m_stale = 1'b1;
    for (int i = 0; i < 4; i++) m_nib[i] = 0;
    m_last.cyc = 0; m_last.value = 0; m_last.dp = 0; m_last.blank = 0; m_last.err = 0;
  endtask

  task automatic model_capture(input int i, input logic [6:0] p, input logic dpb, input int k);
    frame_t f;
    m_nib[i] = 0;
    for (int n = 0; n < 16; n++) if (gl[n] == p) m_nib[i] = 4'(n);
    m_blank[i] = (p == 7'h00);
    m_bad[i]   = (p != 7'h00) && !is_glyph(p);
    m_dp[i]    = dpb;
    m_mask[i]  = 1'b1;
    if (m_mask == 4'hF) begin
      f.cyc   = k + SETTLE + 1;
      f.value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      f.dp    = m_dp;
      f.blank = m_blank;
      f.err   = |m_bad;
      exp_q.push_back(f);
      m_last  = f;
      m_stale = 1'b0;
      m_mask  = 0; m_bad = 0; m_blank = 0;
    end
  endtask

  // Pins change #1 after edge k and stay for n edges.
  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input logic sp,
                       input int n, output int k);
    AN = an; seg = sg; seg_P = sp;
    k = cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int k;
    drive(4'hF, 7'h7F, 1'b1, n, k);
    if (n >= TIMEOUT + 8) begin
      m_mask  = 0;
      m_stale = 1'b1;
    end
  endtask

  task automatic put_digit(input int i, input logic [6:0] p, input logic dpb,
                           input int hold, input int gap);
    int k;
    logic [3:0] an;
    an = ~(4'(1) << i);
    drive(an, ~p, ~dpb, hold, k);
    if (hold >= SETTLE) model_capture(i, p, dpb, k);
    if (gap > 0) idle(gap);
  endtask

  task automatic bad_an(input logic [3:0] an, input int hold);
    int k;
    drive(an, 7'h00, 1'b1, hold, k);
    if (hold >= SETTLE) an_err_exp++;
    idle(2);
  endtask

  task automatic flush(input string tag);
    frame_t o, e;
    idle(8);
    check({tag, ".frames"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, ".cyc"},   o.cyc,   e.cyc);
      check({tag, ".value"}, o.value, e.value);
      check({tag, ".dp"},    o.dp,    e.dp);
      check({tag, ".blank"}, o.blank, e.blank);
      check({tag, ".err"},   o.err,   e.err);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, ".stale"},     stale,       m_stale);
    check({tag, ".hold_val"},  value,       m_last.value);
    check({tag, ".hold_dp"},   dp,          m_last.dp);
    check({tag, ".hold_blk"},  blank,       m_last.blank);
    check({tag, ".hold_err"},  frame_err,   m_last.err);
    check({tag, ".an_err"},    an_err_seen, an_err_exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".value"}, value,       16'h0);
    check({tag, ".dp"},    dp,          4'h0);
    check({tag, ".blank"}, blank,       4'h0);
    check({tag, ".fv"},    frame_valid, 1'b0);
    check({tag, ".ferr"},  frame_err,   1'b0);
    check({tag, ".anerr"}, an_err,      1'b0);
    check({tag, ".stale"}, stale,       1'b1);
  endtask

  function automatic logic [6:0] rand_pattern();
    int r;
    logic [6:0] p;
    r = $urandom_range(0, 9);
    if (r == 0) return 7'h00;
    if (r == 1) begin
      do p = 7'($urandom); while (p == 7'h00 || is_glyph(p));
      return p;
    end
    return gl[$urandom_range(0, 15)];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    logic [3:0] an;
    gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: idle bus, stale stays high
    for (int c = 0; c < 70; c++) begin
      idle(1);
      check("idle.stale", stale, 1'b1);
    end
    flush("idle");

    // 2: plain scan 1234, dp on digit 2
    put_digit(0, gl[4], 1'b0, 8, 2);
    put_digit(1, gl[3], 1'b0, 8, 2);
    put_digit(2, gl[2], 1'b1, 8, 2);
    put_digit(3, gl[1], 1'b0, 8, 2);
    flush("scan");
    check("scan.value_1234", value, 16'h1234);
    check("scan.dp_0100",    dp,    4'b0100);

    // 3: illegal digit 1, blank digit 3
    put_digit(0, gl[4], 1'b0, 8, 2);
    put_digit(1, 7'h55, 1'b0, 8, 2);
    put_digit(2, gl[2], 1'b0, 8, 2);
    put_digit(3, 7'h00, 1'b0, 8, 2);
    flush("bad");
    check("bad.value_0204", value,     16'h0204);
    check("bad.ferr",       frame_err, 1'b1);
    check("bad.blank_1000", blank,     4'b1000);

    // 4: multi-hot anode mid-frame
    put_digit(0, gl[8], 1'b0, 6, 2);
    put_digit(1, gl[9], 1'b1, 6, 2);
    bad_an(4'b1100, 8);
    put_digit(2, gl[10], 1'b0, 6, 2);
    put_digit(3, gl[11], 1'b0, 6, 2);
    flush("anerr");
    check("anerr.value", value, 16'hBA98);

    // 5: glyph changing faster than SETTLE, then settling
    put_digit(0, gl[9], 1'b0, 3, 0);
    put_digit(0, gl[8], 1'b0, 3, 0);
    put_digit(0, gl[7], 1'b0, 3, 0);
    put_digit(0, gl[6], 1'b0, 3, 0);
    put_digit(0, gl[5], 1'b0, 6, 2);
    put_digit(1, gl[0], 1'b0, 6, 2);
    put_digit(2, gl[0], 1'b0, 6, 2);
    put_digit(3, gl[0], 1'b0, 6, 2);
    flush("settle");
    check("settle.digit0", value[3:0], 4'h5);

    // timeout discards a partial frame
    put_digit(0, gl[1], 1'b0, 6, 2);
    put_digit(1, gl[2], 1'b0, 6, 2);
    idle(80);
    put_digit(2, gl[3], 1'b0, 6, 2);
    put_digit(3, gl[4], 1'b0, 6, 2);
    flush("tmo_part");
    put_digit(0, gl[5], 1'b0, 6, 2);
    put_digit(1, gl[6], 1'b0, 6, 2);
    flush("tmo_done");
    check("tmo_done.value", value, 16'h4365);
    idle(80);
    flush("tmo_clear");

    // 6: reset mid-frame discards captured digits
    put_digit(0, gl[7], 1'b0, 6, 2);
    put_digit(1, gl[7], 1'b0, 6, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_lo1");
    @(negedge clk);
    check_reset_outputs("rst_lo2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    put_digit(0, gl[10], 1'b0, 6, 2);
    put_digit(1, gl[11], 1'b0, 6, 2);
    put_digit(2, gl[12], 1'b0, 6, 2);
    put_digit(3, gl[13], 1'b0, 6, 2);
    flush("rst");
    check("rst.value_dCbA", value, 16'hDCBA);

    // randomised frames
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) < 2)
          put_digit(i, rand_pattern(), 1'($urandom), $urandom_range(4, 8), $urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) begin
          do an = 4'($urandom); while ($onehot(~an) || an == 4'hF);
          bad_an(an, $urandom_range(2, 7));
        end
        hold = ($urandom_range(0, 99) < 15) ? $urandom_range(2, 3) : $urandom_range(4, 9);
        put_digit(i, rand_pattern(), 1'($urandom), hold, $urandom_range(1, 3));
      end
      flush("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
